hyperbus_tx_serializer: RTL and testbench
=========================================

# hyperbus_tx_serializer

Transmit-side word-to-byte serializer for the HyperBus PHY, the outgoing counterpart to the read-strobe delay path. Accepts 16-bit write words with per-byte strobes over a valid/ready handshake and emits one byte per clock on DQ, with DQ/RWDS output enables, the RWDS write mask and a CK-enable for the clock generator. It runs in the PHY clock domain at twice the CK frequency, so one clock corresponds to one CK edge.

## Interface
- POST_CYCLES, default 2: CK-enabled cycles after the last word with DQ released (range 0..15).
- clk_i  in  1  PHY clock, 2x CK frequency.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous abort; highest priority after reset.
- tx_valid_i  in  1  word valid.
- tx_ready_o  out  1  word accepted when valid && ready.
- tx_data_i  in  16  write word; [15:8] is sent first.
- tx_strb_i  in  2  byte strobes; bit1 covers [15:8], bit0 covers [7:0].
- tx_last_i  in  1  last word of the burst.
- dq_o  out  8  DQ output byte.
- dq_oe_o  out  1  DQ output enable.
- rwds_o  out  1  write mask; high means byte masked, i.e. ~strobe.
- rwds_oe_o  out  1  RWDS output enable.
- ck_en_o  out  1  CK toggle enable to the clock generator.
- busy_o  out  1  state != IDLE.
- underrun_o  out  1  one-cycle pulse on entry to STALL.

## Operation
- States: IDLE, HI, LO, STALL, POST.
- IDLE:
  - tx_ready_o=1.
  - On accept: latch data/strb/last, go to HI.
  - With POST_CYCLES=0 and no accept: stay in IDLE.
- HI:
  - dq_o=data[15:8], rwds_o=~strb[1].
  - dq_oe_o=rwds_oe_o=ck_en_o=1, tx_ready_o=0.
  - Next state: LO.
- LO:
  - dq_o=data[7:0], rwds_o=~strb[0].
  - Enables as in HI.
  - tx_ready_o = ~last_q.
- Transitions from LO:
  - last_q=1: go to POST; go to IDLE instead when POST_CYCLES=0.
  - last_q=0 and accept: latch the new word, go to HI.
  - last_q=0 and no valid: go to STALL and pulse underrun_o.
- STALL:
  - ck_en_o=0; dq_oe_o and rwds_oe_o stay 1.
  - dq_o and rwds_o hold the LO values.
  - tx_ready_o=1; on accept go to HI.
- POST:
  - dq_oe_o=0, rwds_oe_o=0, ck_en_o=1, tx_ready_o=0.
  - A 4-bit counter loads POST_CYCLES-1 on entry and decrements each cycle.
  - Go to IDLE when the counter reaches 0.
- tx_last_i, tx_data_i and tx_strb_i are sampled only on accept.
- A word accepted in IDLE with last=1 produces exactly HI, LO, then POST.
- clear_i: next state is IDLE, counter is cleared and no word is accepted in that cycle, whatever the current state. A word presented in the same cycle is dropped.
- Strobe 2'b00 is legal: the bytes are still sent with rwds_o=1 and CK runs normally.

## Timing
- Reset values:
  - dq_o=8'h00, rwds_o=0.
  - dq_oe_o, rwds_oe_o, ck_en_o, busy_o, underrun_o all 0.
  - tx_ready_o=1 (IDLE).
- All outputs are registered state decodes. tx_ready_o is combinational from state and last_q only, never from tx_valid_i.
- Latency: a word accepted at cycle N drives its high byte in N+1 and its low byte in N+2.
- Continuous valid gives full throughput: 2 cycles per word with no bubble.
- Asynchronous reset mid-burst immediately deasserts every enable.

## Configuration
- HYPERBUS_TX_OREG_EN defined:
  - dq_o, dq_oe_o, rwds_o, rwds_oe_o and ck_en_o pass through one extra register stage, giving +1 cycle latency (high byte at N+2).
  - Handshake and state timing are unchanged.
  - The extra stage resets to the same values as above.
- HYPERBUS_TX_OREG_EN undefined: outputs come directly from the state registers.

## Structure
- Shared package hyperbus_pkg holds:
  - the enum hyperbus_tx_state_e {IDLE, HI, LO, STALL, POST};
  - the localparam HYPERBUS_POST_W=4.
- One sub-module, hyperbus_tx_oreg: the optional output retiming stage. It is instantiated only under HYPERBUS_TX_OREG_EN.

## Test plan
- Single word 16'hA55A, strb 2'b11, last=1, POST_CYCLES=2:
  - dq_o shows A5 then 5A with oe=1 and rwds_o=0.
  - Then 2 cycles with ck_en=1 and oe=0, then IDLE.
- Four back-to-back words 1111, 2222, 3333, 4444 (last on the fourth):
  - 8 consecutive byte cycles with ck_en_o continuously 1.
  - tx_ready_o high only in LO/IDLE.
- Word 16'hBEEF with strb 2'b10: rwds_o is 0 during BE and 1 during EF.
- Drop valid after word 1 (last=0) for 3 cycles:
  - underrun_o pulses once.
  - ck_en_o is 0 for those 3 cycles while dq_o holds the low byte.
  - The next word resumes with its high byte.
- Assert clear_i during HI of a burst: next cycle IDLE, all enables 0, tx_ready_o=1.
- Pulse rst_ni low during STALL: outputs take reset values asynchronously.
- Repeat test 1 with HYPERBUS_TX_OREG_EN: waveforms are identical but shifted by 1 cycle.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// ---------------------------------------------------------------------------
// hyperbus_pkg
// Shared types and constants for the HyperBus PHY transmit path.
//   hyperbus_tx_state_e : serializer FSM states
//   HYPERBUS_POST_W     : width of the post-burst CK counter
// ---------------------------------------------------------------------------
package hyperbus_pkg;

  localparam int HYPERBUS_POST_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    STALL,
    POST
  } hyperbus_tx_state_e;

endpackage

// File: rtl/hyperbus_tx_oreg.sv
// ---------------------------------------------------------------------------
// hyperbus_tx_oreg
// Optional retiming stage for the pad-facing serializer outputs. It adds one
// clock of latency to DQ, RWDS, their output enables and the CK enable, and
// resets to the same idle values as the serializer itself.
// Ports:
//   clk_i, rst_ni            PHY clock, async active-low reset
//   dq_i/dq_oe_i/rwds_i/
//   rwds_oe_i/ck_en_i        undelayed pad signals
//   dq_o/dq_oe_o/rwds_o/
//   rwds_oe_o/ck_en_o        retimed pad signals
// ---------------------------------------------------------------------------
module hyperbus_tx_oreg (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] dq_i,
  input  logic       dq_oe_i,
  input  logic       rwds_i,
  input  logic       rwds_oe_i,
  input  logic       ck_en_i,
  output logic [7:0] dq_o,
  output logic       dq_oe_o,
  output logic       rwds_o,
  output logic       rwds_oe_o,
  output logic       ck_en_o
);

  logic [7:0] dq_q;
  logic       dq_oe_q;
  logic       rwds_q;
  logic       rwds_oe_q;
  logic       ck_en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dq_q      <= 8'h00;
      dq_oe_q   <= 1'b0;
      rwds_q    <= 1'b0;
      rwds_oe_q <= 1'b0;
      ck_en_q   <= 1'b0;
    end else begin
      dq_q      <= dq_i;
      dq_oe_q   <= dq_oe_i;
      rwds_q    <= rwds_i;
      rwds_oe_q <= rwds_oe_i;
      ck_en_q   <= ck_en_i;
    end
  end

  assign dq_o      = dq_q;
  assign dq_oe_o   = dq_oe_q;
  assign rwds_o    = rwds_q;
  assign rwds_oe_o = rwds_oe_q;
  assign ck_en_o   = ck_en_q;

endmodule

// File: rtl/hyperbus_tx_serializer.sv
// ---------------------------------------------------------------------------
// hyperbus_tx_serializer
// Transmit word-to-byte serializer for the HyperBus PHY. Takes 16-bit write
// words with byte strobes over valid/ready and emits one byte per PHY clock
// (one CK edge), high byte first, with DQ/RWDS enables, the RWDS write mask
// and a CK enable for the clock generator.
// Parameters:
//   POST_CYCLES  CK-enabled cycles after the last word with DQ released (0..15)
// Ports:
//   clk_i, rst_ni      PHY clock (2x CK), async active-low reset
//   clear_i            synchronous abort back to IDLE
//   tx_valid_i/tx_ready_o, tx_data_i, tx_strb_i, tx_last_i   word input
//   dq_o, dq_oe_o, rwds_o, rwds_oe_o, ck_en_o                pad side
//   busy_o             FSM not idle
//   underrun_o         one-cycle pulse on entry to STALL
// Build option:
//   HYPERBUS_TX_OREG_EN  adds one register stage on the pad-side outputs
// ---------------------------------------------------------------------------
module hyperbus_tx_serializer
  import hyperbus_pkg::*;
#(
  parameter int POST_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [15:0] tx_data_i,
  input  logic [1:0]  tx_strb_i,
  input  logic        tx_last_i,
  output logic [7:0]  dq_o,
  output logic        dq_oe_o,
  output logic        rwds_o,
  output logic        rwds_oe_o,
  output logic        ck_en_o,
  output logic        busy_o,
  output logic        underrun_o
);

  // Counter load value; the POST_CYCLES=0 case never enters POST.
  localparam logic [HYPERBUS_POST_W-1:0] POST_LOAD =
    (POST_CYCLES == 0) ? '0 : HYPERBUS_POST_W'(POST_CYCLES - 1);

  hyperbus_tx_state_e         state_q, state_d;
  logic [15:0]                data_q, data_d;
  logic [1:0]                 strb_q, strb_d;
  logic                       last_q, last_d;
  logic [HYPERBUS_POST_W-1:0] cnt_q, cnt_d;
  logic                       underrun_q, underrun_d;

  logic                       accept;
  logic [7:0]                 dq_s;
  logic                       rwds_s;
  logic                       oe_s;
  logic                       ck_en_s;

  // Ready depends only on state and last_q so it never loops through valid.
  always_comb begin
    tx_ready_o = 1'b0;
    case (state_q)
      IDLE:    tx_ready_o = 1'b1;
      LO:      tx_ready_o = ~last_q;
      STALL:   tx_ready_o = 1'b1;
      default: tx_ready_o = 1'b0;
    endcase
  end

  // clear_i blocks acceptance so a word presented with it is dropped.
  assign accept = tx_valid_i & tx_ready_o & ~clear_i;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    strb_d     = strb_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    underrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = HI;
      end
      HI: begin
        state_d = LO;
      end
      LO: begin
        if (last_q) begin
          if (POST_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = POST;
            cnt_d   = POST_LOAD;
          end
        end else if (accept) begin
          state_d = HI;
        end else if (!tx_valid_i) begin
          state_d    = STALL;
          underrun_d = 1'b1;
        end
      end
      STALL: begin
        if (accept) state_d = HI;
      end
      POST: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      data_d = tx_data_i;
      strb_d = tx_strb_i;
      last_d = tx_last_i;
    end

    if (clear_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      data_q     <= 16'h0000;
      strb_q     <= 2'b00;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
    end
  end

  // Pad-side decode. STALL keeps driving the low byte with CK parked.
  always_comb begin
    dq_s    = 8'h00;
    rwds_s  = 1'b0;
    oe_s    = 1'b0;
    ck_en_s = 1'b0;
    case (state_q)
      HI: begin
        dq_s    = data_q[15:8];
        rwds_s  = ~strb_q[1];
        oe_s    = 1'b1;
        ck_en_s = 1'b1;
      end
      LO: begin
        dq_s    = data_q[7:0];
        rwds_s  = ~strb_q[0];
        oe_s    = 1'b1;
        ck_en_s = 1'b1;
      end
      STALL: begin
        dq_s    = data_q[7:0];
        rwds_s  = ~strb_q[0];
        oe_s    = 1'b1;
        ck_en_s = 1'b0;
      end
      POST: begin
        ck_en_s = 1'b1;
      end
      default: begin
        dq_s    = 8'h00;
      end
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign underrun_o = underrun_q;

`ifdef HYPERBUS_TX_OREG_EN
  hyperbus_tx_oreg u_oreg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .dq_i      (dq_s),
    .dq_oe_i   (oe_s),
    .rwds_i    (rwds_s),
    .rwds_oe_i (oe_s),
    .ck_en_i   (ck_en_s),
    .dq_o      (dq_o),
    .dq_oe_o   (dq_oe_o),
    .rwds_o    (rwds_o),
    .rwds_oe_o (rwds_oe_o),
    .ck_en_o   (ck_en_o)
  );
`else
  assign dq_o      = dq_s;
  assign dq_oe_o   = oe_s;
  assign rwds_o    = rwds_s;
  assign rwds_oe_o = oe_s;
  assign ck_en_o   = ck_en_s;
`endif

endmodule

// File: tb/tb_hyperbus_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_hyperbus_tx_serializer
// Directed bench for hyperbus_tx_serializer. Expected pad and handshake
// values for the following cycle are queued whenever stimulus is driven and
// compared at the next falling edge. Pad expectations are offset by one
// queue entry when HYPERBUS_TX_OREG_EN is defined.
// ---------------------------------------------------------------------------
module tb_hyperbus_tx_serializer;

  localparam int P = 2;
`ifdef HYPERBUS_TX_OREG_EN
  localparam int OL = 1;
`else
  localparam int OL = 0;
`endif

  typedef struct packed {
    logic [7:0] dq;
    logic       dq_oe;
    logic       rwds;
    logic       rwds_oe;
    logic       ck_en;
  } pins_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic underrun;
  } hs_t;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic [1:0]  tx_strb;
  logic        tx_last;
  logic [7:0]  dq;
  logic        dq_oe;
  logic        rwds;
  logic        rwds_oe;
  logic        ck_en;
  logic        busy;
  logic        underrun;

  pins_t pq[$];
  hs_t   hq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  string tag    = "reset";

  localparam pins_t PINS_RST = '{dq: 8'h00, dq_oe: 1'b0, rwds: 1'b0, rwds_oe: 1'b0, ck_en: 1'b0};
  localparam hs_t   HS_RST   = '{ready: 1'b1, busy: 1'b0, underrun: 1'b0};

  hyperbus_tx_serializer #(.POST_CYCLES(P)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .tx_data_i  (tx_data),
    .tx_strb_i  (tx_strb),
    .tx_last_i  (tx_last),
    .dq_o       (dq),
    .dq_oe_o    (dq_oe),
    .rwds_o     (rwds),
    .rwds_oe_o  (rwds_oe),
    .ck_en_o    (ck_en),
    .busy_o     (busy),
    .underrun_o (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pins_t obs_pins();
    return '{dq: dq, dq_oe: dq_oe, rwds: rwds, rwds_oe: rwds_oe, ck_en: ck_en};
  endfunction

  function automatic hs_t obs_hs();
    return '{ready: tx_ready, busy: busy, underrun: underrun};
  endfunction

  task automatic check_now(input pins_t pe, input hs_t he);
    pins_t po;
    hs_t   ho;
    po = obs_pins();
    ho = obs_hs();
    checks++;
    assert (po === pe) else begin
      errors++;
      $error("FAIL %s pins cyc=%0d observed=%h expected=%h", tag, cyc, po, pe);
    end
    checks++;
    assert (ho === he) else begin
      errors++;
      $error("FAIL %s handshake cyc=%0d observed=%b expected=%b", tag, cyc, ho, he);
    end
  endtask

  // Advance to the next falling edge and compare against the queue heads.
  task automatic tick();
    pins_t pe;
    hs_t   he;
    @(negedge clk);
    cyc++;
    pe = pq.pop_front();
    he = hq.pop_front();
    check_now(pe, he);
    $display("cyc=%0d %s dq=%h oe=%b rwds=%b ck=%b rdy=%b busy=%b ur=%b",
             cyc, tag, dq, dq_oe, rwds, ck_en, tx_ready, busy, underrun);
  endtask

  // Queue what the next cycle must look like, then step into it.
  task automatic nxt(input logic [7:0] d, input logic oe, input logic rw,
                     input logic ck, input logic rdy, input logic bsy, input logic ur);
    pq.push_back('{dq: d, dq_oe: oe, rwds: rw, rwds_oe: oe, ck_en: ck});
    hq.push_back('{ready: rdy, busy: bsy, underrun: ur});
    tick();
  endtask

  task automatic idle_inputs();
    tx_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic exp_idle();
    nxt(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Present a word in a ready cycle; leaves the bench in the word's LO cycle.
  task automatic send_word(input logic [15:0] d, input logic [1:0] s, input logic l);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_strb  = s;
    tx_last  = l;
    nxt(d[15:8], 1'b1, ~s[1], 1'b1, 1'b0, 1'b1, 1'b0);
    // Scramble inputs so only the accept-cycle values can matter.
    tx_valid = 1'b0;
    tx_data  = 16'($urandom);
    tx_strb  = 2'($urandom);
    tx_last  = 1'($urandom);
    nxt(d[7:0], 1'b1, ~s[0], 1'b1, ~l, 1'b1, 1'b0);
  endtask

  task automatic finish_post();
    idle_inputs();
    repeat (P) nxt(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_idle();
  endtask

  task automatic prime_queues();
    pq.delete();
    hq.delete();
    repeat (OL) pq.push_back(PINS_RST);
  endtask

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 16'h0000;
    tx_strb  = 2'b00;
    tx_last  = 1'b0;

    // Reset values while held in reset.
    @(negedge clk);
    @(negedge clk);
    check_now(PINS_RST, HS_RST);
    rst_n = 1'b1;
    prime_queues();
    exp_idle();

    tag = "single_a55a";
    send_word(16'hA55A, 2'b11, 1'b1);
    finish_post();

    tag = "b2b4";
    send_word(16'h1111, 2'b11, 1'b0);
    send_word(16'h2222, 2'b11, 1'b0);
    send_word(16'h3333, 2'b11, 1'b0);
    send_word(16'h4444, 2'b11, 1'b1);
    finish_post();

    tag = "mask_beef";
    send_word(16'hBEEF, 2'b10, 1'b1);
    finish_post();

    tag = "strb00";
    send_word(16'h1234, 2'b00, 1'b1);
    finish_post();

    tag = "underrun";
    send_word(16'hC3D4, 2'b01, 1'b0);
    idle_inputs();
    nxt(8'hD4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    nxt(8'hD4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    nxt(8'hD4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_word(16'h7E81, 2'b11, 1'b1);
    finish_post();

    tag = "clear_hi";
    tx_valid = 1'b1;
    tx_data  = 16'h5AA5;
    tx_strb  = 2'b11;
    tx_last  = 1'b0;
    nxt(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    clear   = 1'b1;
    tx_data = 16'h6699;
    exp_idle();
    idle_inputs();
    exp_idle();

    tag = "clear_drop";
    clear    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 16'hF00F;
    exp_idle();
    idle_inputs();
    exp_idle();

    tag = "rst_stall";
    send_word(16'h9ABC, 2'b11, 1'b0);
    idle_inputs();
    nxt(8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_now(PINS_RST, HS_RST);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    prime_queues();
    exp_idle();

    tag = "after_rst";
    send_word(16'h0F0F, 2'b11, 1'b1);
    finish_post();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
